// File: rtl/data_merger.sv
// Two-channel frame recombiner: the first stagecnt words of each frame come from
// channel 1, the remaining num-stagecnt words from channel 2, one word in flight.
module data_merger #(
  parameter int DW = 32,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [CW-1:0] stagecnt,
  input  logic [CW-1:0] num,
  input  logic          idata1_rdy,
  output logic          idata1_pop,
  input  logic [DW-1:0] idata1,
  input  logic          idata2_rdy,
  output logic          idata2_pop,
  input  logic [DW-1:0] idata2,
  output logic          odata_push,
  input  logic          odata_rdy,
  output logic [DW-1:0] odata,
  output logic          busy,
  output logic          frame_done
);

  typedef enum logic [2:0] {IDLE, POP, WAIT, PUSH, DONE} state_t;

  state_t        state;
  logic [CW-1:0] num_r, stage_r, cnt;
  logic [DW-1:0] hold;

  logic          sel1, src_rdy;
  logic [CW-1:0] cnt_nx;

  assign sel1    = cnt < stage_r;
  assign src_rdy = sel1 ? idata1_rdy : idata2_rdy;
  assign cnt_nx  = cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      num_r   <= '0;
      stage_r <= '0;
      cnt     <= '0;
      hold    <= '0;
    end else begin
      case (state)
        IDLE: if (en && num != '0) begin
          num_r   <= num;
          stage_r <= (stagecnt < num) ? stagecnt : num;
          cnt     <= '0;
          state   <= POP;
        end
        POP:  if (src_rdy) state <= WAIT;
        // source FIFO data is valid the cycle after the pop
        WAIT: begin
          hold  <= sel1 ? idata1 : idata2;
          state <= PUSH;
        end
        PUSH: if (odata_rdy) begin
          cnt   <= cnt_nx;
          state <= (cnt_nx == num_r) ? DONE : POP;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are gated by rst so every output reads 0 in the reset cycle itself.
  assign idata1_pop = !rst && state == POP && sel1 && idata1_rdy;
  assign idata2_pop = !rst && state == POP && !sel1 && idata2_rdy;
  assign odata_push = !rst && state == PUSH && odata_rdy;
  assign odata      = rst ? '0 : hold;
  assign busy       = !rst && state != IDLE;
  assign frame_done = !rst && state == DONE;

endmodule

// File: tb/tb_data_merger.sv
// Randomized bench for data_merger: FIFO models feed both channels and a
// frame-level reference (head from ch1, tail from ch2) checks the output stream.
module tb_data_merger;
  localparam int DW = 32;
  localparam int CW = 32;

  logic          clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [CW-1:0] stagecnt = '0, num = '0;
  logic          idata1_rdy, idata1_pop, idata2_rdy, idata2_pop;
  logic          odata_push, odata_rdy = 1'b1, busy, frame_done;
  logic [DW-1:0] idata1 = '0, idata2 = '0, odata;
  logic          have1 = 1'b0, have2 = 1'b0, starve1 = 1'b0, starve2 = 1'b0;

  assign idata1_rdy = have1 && !starve1;
  assign idata2_rdy = have2 && !starve2;

  always #5 clk = ~clk;

  data_merger #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .stagecnt(stagecnt), .num(num),
    .idata1_rdy(idata1_rdy), .idata1_pop(idata1_pop), .idata1(idata1),
    .idata2_rdy(idata2_rdy), .idata2_pop(idata2_pop), .idata2(idata2),
    .odata_push(odata_push), .odata_rdy(odata_rdy), .odata(odata),
    .busy(busy), .frame_done(frame_done)
  );

  logic [DW-1:0] q1[$], q2[$], outq[$], exp_q[$];
  int            outcyc[$];
  int            p1, p2, nfd, fdcyc, viol, cyc, t0, k1, k2;
  bit            pend1, pend2;
  logic          s_pop1, s_pop2, s_push, s_busy, s_fd;
  logic [DW-1:0] s_odata;
  int            n_chk = 0, n_fail = 0;

  // One clock: sample outputs mid-cycle, then serve FIFO pops just after the edge.
  task automatic tick();
    @(negedge clk);
    s_pop1 = idata1_pop; s_pop2 = idata2_pop; s_push = odata_push;
    s_odata = odata; s_busy = busy; s_fd = frame_done;
    if (s_pop1) begin p1++; pend1 = 1'b1; end
    if (s_pop2) begin p2++; pend2 = 1'b1; end
    if (s_push) begin outq.push_back(s_odata); outcyc.push_back(cyc); end
    if (s_fd) begin nfd++; fdcyc = cyc; end
    if (int'(s_pop1) + int'(s_pop2) + int'(s_push) > 1) viol++;
    if ((s_pop1 && !idata1_rdy) || (s_pop2 && !idata2_rdy) || (s_push && !odata_rdy)) viol++;
    cyc++;
    @(posedge clk); #1;
    if (pend1) begin pend1 = 1'b0; if (q1.size() > 0) idata1 = q1.pop_front(); else viol++; end
    if (pend2) begin pend2 = 1'b0; if (q2.size() > 0) idata2 = q2.pop_front(); else viol++; end
    have1 = q1.size() > 0;
    have2 = q2.size() > 0;
  endtask

  // Reference: frame = first min(s,n) ch1 words, then the rest from ch2.
  task automatic load_frame(input int n, input int s, input int e1, input int e2, input int base);
    logic [DW-1:0] w;
    q1.delete(); q2.delete(); exp_q.delete(); outq.delete(); outcyc.delete();
    p1 = 0; p2 = 0; nfd = 0; pend1 = 1'b0; pend2 = 1'b0;
    k1 = (s < n) ? s : n;
    k2 = n - k1;
    for (int i = 0; i < k1 + e1; i++) begin
      w = (base != 0) ? DW'(base + i) : $urandom;
      q1.push_back(w);
      if (i < k1) exp_q.push_back(w);
    end
    for (int i = 0; i < k2 + e2; i++) begin
      w = (base != 0) ? DW'(base + 'h10 + i) : $urandom;
      q2.push_back(w);
      if (i < k2) exp_q.push_back(w);
    end
    tick(); tick();
  endtask

  task automatic start_frame(input int n, input int s);
    num = CW'(n); stagecnt = CW'(s); en = 1'b1;
    t0 = cyc;
    tick();
    en = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit, input bit rnd, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (rnd) begin
        starve1 = ($urandom_range(0, 3) == 0);
        starve2 = ($urandom_range(0, 3) == 0);
        odata_rdy = ($urandom_range(0, 2) != 0);
      end
      tick();
      if (nfd >= target) begin ok = 1'b1; break; end
    end
    starve1 = 1'b0; starve2 = 1'b0; odata_rdy = 1'b1;
  endtask

  function automatic int words_bad();
    int b = (outq.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < outq.size() && i < exp_q.size(); i++)
      if (outq[i] !== exp_q[i]) b++;
    return b;
  endfunction

  task automatic test_reset();
    int bad = 0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (s_busy || s_pop1 || s_pop2 || s_push || s_fd || s_odata !== '0) bad++;
    end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL reset_outputs: %0d nonzero cycles, expected 0", bad); end
    rst = 1'b0;
    tick();
    n_chk++; if (s_busy !== 1'b0 || s_odata !== '0) begin
      n_fail++; $display("FAIL reset_release: busy=%b odata=%h, expected 0/0", s_busy, s_odata);
    end
  endtask

  task automatic test_basic();
    bit ok; int bad = 0;
    load_frame(5, 2, 0, 0, 'hA0);
    start_frame(5, 2);
    wait_done(1, 100, 1'b0, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL basic_done: timeout, expected frame_done"); end
    n_chk++; if (words_bad() != 0) begin n_fail++; $display("FAIL basic_words: %0d bad words, expected 0", words_bad()); end
    for (int i = 0; i < outcyc.size(); i++) if (outcyc[i] != t0 + 3 + 3 * i) bad++;
    n_chk++; if (bad != 0 || outcyc.size() != 5) begin
      n_fail++; $display("FAIL basic_push_timing: %0d late pushes of %0d, expected 0 of 5", bad, outcyc.size());
    end
    n_chk++; if (fdcyc != t0 + 16) begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected %0d", fdcyc - t0, 16); end
    n_chk++; if (p1 != 2 || p2 != 3) begin n_fail++; $display("FAIL basic_pops: got %0d/%0d expected 2/3", p1, p2); end
  endtask

  task automatic test_degenerate();
    bit ok; int bad = 0;
    load_frame(3, 0, 2, 0, 0);
    start_frame(3, 0);
    wait_done(1, 100, 1'b0, ok);
    n_chk++; if (!ok || words_bad() != 0) begin n_fail++; $display("FAIL stage0_words: ok=%b bad=%0d expected 1/0", ok, words_bad()); end
    n_chk++; if (p1 != 0 || p2 != 3) begin n_fail++; $display("FAIL stage0_pops: got %0d/%0d expected 0/3", p1, p2); end
    load_frame(4, 7, 0, 3, 0);
    start_frame(4, 7);
    wait_done(1, 100, 1'b0, ok);
    n_chk++; if (!ok || words_bad() != 0) begin n_fail++; $display("FAIL stagebig_words: ok=%b bad=%0d expected 1/0", ok, words_bad()); end
    n_chk++; if (p1 != 4 || p2 != 0 || q2.size() != 3) begin
      n_fail++; $display("FAIL stagebig_pops: got %0d/%0d left2=%0d expected 4/0/3", p1, p2, q2.size());
    end
    load_frame(0, 2, 3, 3, 0);
    num = '0; stagecnt = 2; en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_busy || s_pop1 || s_pop2 || s_push) bad++;
    end
    en = 1'b0;
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL num0_idle: %0d active cycles, expected 0", bad); end
  endtask

  task automatic test_starve();
    bit ok; int bad = 0;
    load_frame(3, 2, 0, 0, 0);
    starve1 = 1'b1;
    start_frame(3, 2);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_pop1 || s_pop2 || s_push) bad++;
    end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL starve_quiet: %0d active cycles, expected 0", bad); end
    starve1 = 1'b0;
    wait_done(1, 100, 1'b0, ok);
    n_chk++; if (outcyc.size() == 0 || outcyc[0] != t0 + 13) begin
      n_fail++; $display("FAIL starve_resume: first push at %0d expected %0d", outcyc.size() ? outcyc[0] - t0 : -1, 13);
    end
    n_chk++; if (!ok || words_bad() != 0) begin n_fail++; $display("FAIL starve_words: ok=%b bad=%0d expected 1/0", ok, words_bad()); end
  endtask

  task automatic test_backpressure();
    bit ok; int bad = 0;
    load_frame(2, 1, 0, 0, 0);
    q1[0] = 32'hDEADBEEF; exp_q[0] = 32'hDEADBEEF;
    odata_rdy = 1'b0;
    start_frame(2, 1);
    tick(); tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      if (s_odata !== 32'hDEADBEEF || s_push || s_pop1 || s_pop2) bad++;
    end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold: %0d bad cycles, expected 0", bad); end
    odata_rdy = 1'b1;
    wait_done(1, 100, 1'b0, ok);
    n_chk++; if (outcyc.size() == 0 || outcyc[0] != t0 + 9) begin
      n_fail++; $display("FAIL bp_release: first push at %0d expected %0d", outcyc.size() ? outcyc[0] - t0 : -1, 9);
    end
    n_chk++; if (!ok || words_bad() != 0 || p1 != 1 || p2 != 1) begin
      n_fail++; $display("FAIL bp_words: bad=%0d pops=%0d/%0d expected 0 1/1", words_bad(), p1, p2);
    end
  endtask

  task automatic test_midframe();
    bit ok; int bad = 0;
    load_frame(5, 2, 3, 3, 0);
    num = 5; stagecnt = 2; en = 1'b1;
    for (int i = 0; i < 50 && outq.size() < 1; i++) tick();
    stagecnt = 4; num = 9; en = 1'b0;
    wait_done(1, 100, 1'b0, ok);
    n_chk++; if (!ok || words_bad() != 0) begin n_fail++; $display("FAIL mid_words: ok=%b bad=%0d expected 1/0", ok, words_bad()); end
    n_chk++; if (p1 != 2 || p2 != 3) begin n_fail++; $display("FAIL mid_split: got %0d/%0d expected 2/3", p1, p2); end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_busy || s_pop1 || s_pop2 || s_push) bad++;
    end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL mid_no_restart: %0d active cycles, expected 0", bad); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    load_frame(4, 2, 0, 0, 0);
    start_frame(4, 2);
    tick();
    rst = 1'b1;
    tick();
    n_chk++; if (s_busy || s_pop1 || s_pop2 || s_push || s_fd || s_odata !== '0) begin
      n_fail++; $display("FAIL rst_mid_during: busy=%b odata=%h expected 0/0", s_busy, s_odata);
    end
    rst = 1'b0;
    tick();
    n_chk++; if (s_busy || s_pop1 || s_pop2 || s_push || s_fd || s_odata !== '0) begin
      n_fail++; $display("FAIL rst_mid_after: busy=%b odata=%h expected 0/0", s_busy, s_odata);
    end
    load_frame(3, 1, 0, 0, 0);
    start_frame(3, 1);
    wait_done(1, 100, 1'b0, ok);
    n_chk++; if (!ok || words_bad() != 0 || p1 != 1 || p2 != 2) begin
      n_fail++; $display("FAIL rst_mid_restart: bad=%0d pops=%0d/%0d expected 0 1/2", words_bad(), p1, p2);
    end
  endtask

  task automatic test_back_to_back();
    bit ok = 1'b0;
    load_frame(2, 2, 2, 0, 0);
    exp_q = q1;
    num = 2; stagecnt = 2; en = 1'b1; t0 = cyc;
    for (int i = 0; i < 60 && outq.size() < 3; i++) tick();
    en = 1'b0;
    for (int i = 0; i < 60; i++) begin tick(); if (nfd >= 2) begin ok = 1'b1; break; end end
    n_chk++; if (!ok || words_bad() != 0) begin n_fail++; $display("FAIL b2b_words: ok=%b bad=%0d expected 1/0", ok, words_bad()); end
    n_chk++; if (outcyc.size() < 3 || outcyc[2] != t0 + 11) begin
      n_fail++; $display("FAIL b2b_period: frame2 first push at %0d expected %0d", outcyc.size() > 2 ? outcyc[2] - t0 : -1, 11);
    end
  endtask

  task automatic test_random();
    bit ok; int n, s;
    for (int f = 0; f < 10; f++) begin
      n = $urandom_range(1, 12);
      s = $urandom_range(0, 15);
      load_frame(n, s, $urandom_range(0, 2), $urandom_range(0, 2), 0);
      start_frame(n, s);
      wait_done(1, 3000, 1'b1, ok);
      n_chk++; if (!ok || words_bad() != 0) begin
        n_fail++; $display("FAIL rand_words[%0d]: n=%0d s=%0d ok=%b bad=%0d expected 1/0", f, n, s, ok, words_bad());
      end
      n_chk++; if (p1 != k1 || p2 != k2) begin
        n_fail++; $display("FAIL rand_pops[%0d]: got %0d/%0d expected %0d/%0d", f, p1, p2, k1, k2);
      end
    end
  endtask

  initial begin
    viol = 0; cyc = 0;
    test_reset();
    test_basic();
    test_degenerate();
    test_starve();
    test_backpressure();
    test_midframe();
    test_reset_mid();
    test_back_to_back();
    test_random();
    n_chk++; if (viol != 0) begin n_fail++; $display("FAIL handshake_rules: %0d violations, expected 0", viol); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/data_merger.md
Name: data_merger

Overview:
- Downstream recombiner for the two-channel stage split.
- Reads two source FIFOs through rdy/pop interfaces: channel 1 carries the head of each frame, channel 2 carries the tail.
- Emits one ordered frame of num words on a single push interface: the first stagecnt words from channel 1, then num-stagecnt words from channel 2.
- Processes frames back-to-back while en is high; reports per-frame completion.

Parameters:
DW, 32, data word width
CW, 32, width of stagecnt/num and the internal word counter

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
en  input  1  allow a new frame to start; sampled only in IDLE
stagecnt  input  CW  words taken from channel 1 per frame
num  input  CW  total words per frame
idata1_rdy  input  1  channel-1 FIFO not empty
idata1_pop  output  1  channel-1 pop strobe
idata1  input  DW  channel-1 read data, valid the cycle after pop
idata2_rdy  input  1  channel-2 FIFO not empty
idata2_pop  output  1  channel-2 pop strobe
idata2  input  DW  channel-2 read data, valid the cycle after pop
odata_push  output  1  output push strobe
odata_rdy  input  1  downstream has space
odata  output  DW  output word, valid while odata_push=1
busy  output  1  high in any state other than IDLE
frame_done  output  1  one-cycle pulse after the last word of a frame is pushed

Behaviour:
- Reset: rst is synchronous and active-high; clk is the only clock. Reset forces state IDLE and clears num_r, stage_r, cnt and hold. All outputs are 0 during and after reset. Reset mid-frame abandons the frame; a captured word not yet pushed is dropped.
- States are IDLE, POP, WAIT, PUSH and DONE.
- IDLE:
  - If en=1 and num!=0: latch num_r=num, stage_r=min(stagecnt,num), cnt=0, then go to POP.
  - If num=0: stay in IDLE with no pops and no pushes.
- Channel select: sel1 = (cnt < stage_r), as an unsigned CW-bit compare.
- POP:
  - Selected channel rdy=1: assert that channel's pop for exactly one cycle, then go to WAIT.
  - Selected channel rdy=0: stay in POP.
  - The unselected channel is never popped, even if it is ready.
- WAIT: register the selected channel's data into hold (data is valid this cycle), then go to PUSH.
- PUSH:
  - odata=hold throughout this state.
  - odata_rdy=1: odata_push=1 for one cycle and cnt=cnt+1. If cnt+1==num_r go to DONE, else go to POP.
  - odata_rdy=0: stay in PUSH with odata held stable and no push.
- DONE: frame_done=1 for one cycle, then go to IDLE. Return to IDLE is mandatory, so there is at least one idle cycle between frames.
- Pops and push are decoded combinationally from state and rdy inputs. At most one of idata1_pop, idata2_pop, odata_push is high in any cycle.
- Latency, with all rdy inputs high:
  - IDLE with en=1 at cycle 0 gives POP at cycle 1, WAIT at cycle 2, first push at cycle 3.
  - Steady state is 3 cycles per word.
  - Frame period is 3*num+2 cycles.
- Boundary conditions:
  - stagecnt=0: all words come from channel 2.
  - stagecnt>=num: all num words come from channel 1; channel 2 is untouched.
  - stagecnt, num and en changing mid-frame have no effect; values are latched in IDLE only.
  - en dropping mid-frame: the frame completes.
  - cnt never wraps, because num_r is at most 2^CW-1 and the frame terminates at cnt==num_r.
  - Backpressure on odata_rdy never causes a pop; at most one word is held internally.

Test Plan:
- Basic ordering: num=5, stagecnt=2, ch1 holds A1,A2, ch2 holds B1,B2,B3, all rdy high. Required: odata = A1,A2,B1,B2,B3 with pushes at cycles 3,6,9,12,15; frame_done at cycle 16; exactly 2 pops on ch1 and 3 on ch2.
- Degenerate splits:
  - stagecnt=0, num=3: three ch2 words out, zero ch1 pops.
  - stagecnt=7, num=4: four ch1 words out, zero ch2 pops.
  - num=0 with en=1 for 20 cycles: busy=0, no pops, no pushes.
- Source starvation: ch1 rdy held low 10 cycles in POP. Required: no pops and no pushes during that time; resumes 1 cycle after rdy rises; data order preserved.
- Backpressure: odata_rdy low for 6 cycles in PUSH with hold=0xDEADBEEF. Required: odata stable at 0xDEADBEEF, odata_push=0, no further pops; single push when odata_rdy returns.
- Mid-frame control changes: change stagecnt 2->4 and drop en after the first push (num=5). Required: frame still splits 2/3 and completes; no new frame starts afterward.
- Reset mid-frame: assert rst in WAIT. Required: next cycle IDLE with all outputs 0; a new frame after reset restarts at cnt=0 from ch1.
